// File: rtl/sub_bytes_engine.sv
// sub_bytes_engine: multi-cycle AES SubBytes/InvSubBytes, LANES bytes per cycle.
// Define SBOX_FWD_EN to add forward tables; otherwise every block uses the inverse S-box.
module sub_bytes_engine #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  localparam int NSTEP = 16 / LANES;
  localparam int CW = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("LANES must be 1, 2, 4, 8 or 16");
  end
  localparam logic [0:255][7:0] INV_T = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };
`ifdef SBOX_FWD_EN
  localparam logic [0:255][7:0] FWD_T = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
`endif
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt;
  logic [7:0] work [16];
  logic [7:0] nxt [16];
  logic [7:0] lane [LANES];
  logic [127:0] nxt_flat;
  logic [3:0] base;
  logic accept, last;
  assign in_ready = state == IDLE || (state == DONE && out_ready);
  assign accept = in_valid && in_ready;
  assign last = state == RUN && cnt == CW'(NSTEP - 1);
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  assign base = 4'(int'(cnt) * LANES);
`ifdef SBOX_FWD_EN
  logic mode;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mode <= 1'b0;
    else if (accept) mode <= in_inv;
`else
  wire unused_inv = in_inv;
`endif
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [3:0] idx;
    assign idx = base + 4'(g);
`ifdef SBOX_FWD_EN
    assign lane[g] = mode ? INV_T[work[idx]] : FWD_T[work[idx]];
`else
    assign lane[g] = INV_T[work[idx]];
`endif
  end
  always_comb begin
    nxt = work;
    for (int l = 0; l < LANES; l++) nxt[base + 4'(l)] = lane[l];
    for (int k = 0; k < 16; k++) nxt_flat[127-8*k -: 8] = nxt[k];
  end
  always_comb
    state_d = accept ? RUN : last ? DONE : (state == DONE && out_ready) ? IDLE : state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      out_data <= '0;
      for (int k = 0; k < 16; k++) work[k] <= 8'h00;
    end else begin
      state <= state_d;
      if (accept) begin
        cnt <= '0;
        for (int k = 0; k < 16; k++) work[k] <= in_data[127-8*k -: 8];
      end else if (state == RUN) begin
        cnt <= cnt + 1'b1;
        work <= nxt;
        if (last) out_data <= nxt_flat;
      end
    end
endmodule
